// File: rtl/sort_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sort_pkg : shared defaults and word/frame types for the sorter pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
package sort_pkg;

  localparam int DEFAULT_N     = 6;
  localparam int DEFAULT_WIDTH = 8;

  // All-ones padding sorts to the top indices of an ascending sorter.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PAD = '1;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;
  typedef word_t frame_t [DEFAULT_N];

endpackage
`default_nettype wire

// File: rtl/sort_frame_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sort_frame_bank : one frame buffer (words, count, full flag), pad-masked read
// Rev 1.0
// ----------------------------------------------------------------------------
module sort_frame_bank
  import sort_pkg::*;
#(
  parameter int                N     = DEFAULT_N,
  parameter int                WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  PAD   = {WIDTH{1'b1}},
  parameter int                IW    = (N > 1) ? $clog2(N) : 1,
  parameter int                CW    = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [IW-1:0]             wr_idx_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      close_i,
  input  logic [CW-1:0]             close_count_i,
  input  logic                      release_i,
  output logic                      full_o,
  output logic [CW-1:0]             rd_count_o,
  output logic [N-1:0][WIDTH-1:0]   rd_data_o
);

  logic [N-1:0][WIDTH-1:0] words_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic                    full_q;
  logic                    full_d;

  // A bank cannot be closed and released on the same edge: closing needs it
  // empty, releasing needs it full. Close is given priority regardless.
  always_comb begin
    full_d  = full_q;
    count_d = count_q;
    if (close_i) begin
      full_d  = 1'b1;
      count_d = close_count_i;
    end else if (release_i) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wr_en_i) begin
        words_q[wr_idx_i] <= wr_data_i;
      end
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Contents are never cleared on release; masking hides stale words.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      rd_data_o[k] = (CW'(k) < count_q) ? words_q[k] : PAD;
    end
  end

  assign full_o     = full_q;
  assign rd_count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sort_frame_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sort_frame_loader : packs a serial word stream into padded N-word frames
// Rev 1.0
// ----------------------------------------------------------------------------
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int                N     = DEFAULT_N,
  parameter int                WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  PAD   = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          frame_data [N],
  output logic [$clog2(N+1)-1:0]    frame_count,
  output logic                      frame_valid,
  input  logic                      frame_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [IW-1:0]           wr_idx_q, wr_idx_d;

  logic [1:0]              bank_full;
  logic [CW-1:0]           bank_count [2];
  logic [N-1:0][WIDTH-1:0] bank_data  [2];

  logic                    accept;
  logic                    closing;
  logic                    releasing;
  logic [CW-1:0]           close_count;

  assign in_ready    = !bank_full[wr_bank_q];
  assign frame_valid = bank_full[rd_bank_q];
  assign accept      = in_valid && in_ready;
  assign closing     = accept && (in_last || (wr_idx_q == IW'(N - 1)));
  assign releasing   = frame_valid && frame_ready;
  assign close_count = CW'(wr_idx_q) + CW'(1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sort_frame_bank #(
      .N     (N),
      .WIDTH (WIDTH),
      .PAD   (PAD),
      .IW    (IW),
      .CW    (CW)
    ) u_bank (
      .clk           (clk),
      .rst           (rst),
      .wr_en_i       (accept && (wr_bank_q == 1'(b))),
      .wr_idx_i      (wr_idx_q),
      .wr_data_i     (in_data),
      .close_i       (closing && (wr_bank_q == 1'(b))),
      .close_count_i (close_count),
      .release_i     (releasing && (rd_bank_q == 1'(b))),
      .full_o        (bank_full[b]),
      .rd_count_o    (bank_count[b]),
      .rd_data_o     (bank_data[b])
    );
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (accept) begin
      if (closing) begin
        wr_idx_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_idx_d  = wr_idx_q + IW'(1);
      end
    end
    if (releasing) begin
      rd_bank_d = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      frame_data[k] = bank_data[rd_bank_q][k];
    end
  end

  assign frame_count = bank_count[rd_bank_q];

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sort_frame_loader : scenario tasks plus random traffic against a FIFO model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sort_frame_loader;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int FW = N * W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic [W-1:0]   frame_data [N];
  logic [2:0]     frame_count;
  logic           frame_valid;
  logic           frame_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: closed frames waiting for the consumer, plus the partial frame.
  logic [FW-1:0]  mq_data [$];
  int             mq_cnt  [$];
  logic [W-1:0]   part    [$];
  bit             last_acc;

  always #5 clk = ~clk;

  sort_frame_loader #(.N(N), .WIDTH(W), .PAD(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  function automatic logic [FW-1:0] dut_frame();
    logic [FW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = frame_data[k];
    return v;
  endfunction

  task automatic model_reset();
    mq_data.delete();
    mq_cnt.delete();
    part.delete();
  endtask

  task automatic model_close();
    logic [FW-1:0] v;
    v = '1;
    foreach (part[k]) v[k*W +: W] = part[k];
    mq_data.push_back(v);
    mq_cnt.push_back(part.size());
    part.delete();
  endtask

  // Drive one cycle; the model decides acceptance from its own queue depth.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    bit acc, rel;
    in_valid = v; in_data = d; in_last = l; frame_ready = r;
    acc = v && (mq_cnt.size() < 2);
    rel = r && (mq_cnt.size() > 0);
    @(posedge clk); #1;
    if (rel) begin
      void'(mq_data.pop_front());
      void'(mq_cnt.pop_front());
    end
    if (acc) begin
      part.push_back(d);
      if (l || part.size() == N) model_close();
    end
    last_acc = acc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    checks++; if (frame_count !== 3'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    checks++; if (dut_frame() !== {FW{1'b1}}) begin errors++; $display("FAIL reset_frame_data: got %h want all FF", dut_frame()); end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_frame_valid: got %b want 0", frame_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid: got %b want 1", frame_valid); end
    checks++; if (dut_frame() !== 48'h262524232221) begin errors++; $display("FAIL postreset_data: got %h want 262524232221", dut_frame()); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL postreset_release: got %b want 0", frame_valid); end
  endtask

  task automatic test_full_frame();
    logic [W-1:0] ws [6];
    ws = '{8'h05, 8'h03, 8'h09, 8'h01, 8'h07, 8'h02};
    for (int i = 0; i < 6; i++) step(1'b1, ws[i], 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", frame_valid); end
    checks++; if (frame_count !== 3'd6) begin errors++; $display("FAIL full_count: got %0d want 6", frame_count); end
    checks++; if (dut_frame() !== 48'h020701090305) begin errors++; $display("FAIL full_data: got %h want 020701090305", dut_frame()); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_release: got %b want 0", frame_valid); end
  endtask

  task automatic test_short_frame();
    step(1'b1, 8'h0A, 1'b0, 1'b1);
    step(1'b1, 8'h04, 1'b1, 1'b1);
    checks++; if (frame_count !== 3'd2) begin errors++; $display("FAIL short_count: got %0d want 2", frame_count); end
    checks++; if (dut_frame() !== 48'hFFFFFFFF040A) begin errors++; $display("FAIL short_data: got %h want FFFFFFFF040A", dut_frame()); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
      if (last_acc) acc++;
      if (acc == 12 && i == 11) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
      end
    end
    checks++; if (acc != 12) begin errors++; $display("FAIL bp_accepted: model accepted %0d want 12", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
    checks++; if (dut_frame() !== 48'h363534333231) begin errors++; $display("FAIL bp_frame1: got %h want 363534333231", dut_frame()); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_frame2_valid: got %b want 1", frame_valid); end
    checks++; if (dut_frame() !== 48'h3C3B3A393837) begin errors++; $display("FAIL bp_frame2: got %h want 3C3B3A393837", dut_frame()); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (dut_frame() !== 48'h3C3B3A393837 || frame_count !== 3'd6) begin
      errors++; $display("FAIL bp_stable: got %h cnt %0d want 3C3B3A393837 cnt 6", dut_frame(), frame_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", frame_valid); end
  endtask

  task automatic test_overlong();
    for (int i = 0; i < 7; i++) step(1'b1, 8'(i + 1), (i == 6), 1'b0);
    checks++; if (frame_count !== 3'd6 || dut_frame() !== 48'h060504030201) begin
      errors++; $display("FAIL over_first: got %h cnt %0d want 060504030201 cnt 6", dut_frame(), frame_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_count !== 3'd1 || dut_frame() !== 48'hFFFFFFFFFF07) begin
      errors++; $display("FAIL over_second: got %h cnt %0d want FFFFFFFFFF07 cnt 1", dut_frame(), frame_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL over_drain: got %b want 0", frame_valid); end
    for (int i = 0; i < 6; i++) step(1'b1, 8'h41 + 8'(i), (i == 5), 1'b0);
    checks++; if (frame_valid !== 1'b1 || in_ready !== 1'b1 || frame_count !== 3'd6) begin
      errors++; $display("FAIL last6_one: valid %b ready %b cnt %0d want 1 1 6", frame_valid, in_ready, frame_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL last6_no_empty: got %b want 0", frame_valid); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL simul_state: valid %b ready %b want 1 1", frame_valid, in_ready);
    end
    checks++; if (dut_frame() !== 48'h666564636261 || frame_count !== 3'd6) begin
      errors++; $display("FAIL simul_data: got %h cnt %0d want 666564636261 cnt 6", dut_frame(), frame_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b want 0", frame_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d: got %b want 1", i, in_ready); end
      if (mq_cnt.size() > 0) begin
        checks++; if (dut_frame() !== mq_data[0]) begin errors++; $display("FAIL b2b_data cyc %0d: got %h want %h", i, dut_frame(), mq_data[0]); end
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
      checks++; if (in_ready !== (mq_cnt.size() < 2)) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", i, in_ready, (mq_cnt.size() < 2));
      end
      checks++; if (frame_valid !== (mq_cnt.size() > 0)) begin
        errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", i, frame_valid, (mq_cnt.size() > 0));
      end
      if (mq_cnt.size() > 0) begin
        checks++; if (frame_count !== 3'(mq_cnt[0]) || dut_frame() !== mq_data[0]) begin
          errors++; $display("FAIL rand_frame cyc %0d: got %h cnt %0d want %h cnt %0d", i, dut_frame(), frame_count, mq_data[0], mq_cnt[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_overlong();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_frame_loader.md
# sort_frame_loader

Upstream feeder for the combinational N-input sorter. Accepts a serial valid/ready stream of WIDTH-bit words and packs them into frames of N words. Short frames closed by `in_last` are padded. Complete frames are presented as a parallel array with a valid/ready handshake. Two ping-pong banks let one frame be filled while the previous frame is held for the sorter.

## Interface
- `N`, 6: words per frame (≥2)
- `WIDTH`, 8: word width in bits
- `PAD`, all-ones: fill value for unused slots, chosen so pads sort to the top indices
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_data` in WIDTH: input word
- `in_valid` in 1: `in_data` is valid
- `in_last` in 1: qualified by `in_valid`; this word closes the frame
- `in_ready` out 1: loader can accept a word this cycle
- `frame_data` out WIDTH × [N]: unpacked array, slot k = k-th accepted word, or PAD if k ≥ `frame_count`
- `frame_count` out $clog2(N+1): number of real words in the frame, 1..N
- `frame_valid` out 1: frame presented
- `frame_ready` in 1: consumer takes the frame

## Operation
- Two banks, 0 and 1. Each bank holds N word registers, a count register and a full flag.
- Pointers:
  - `wr_bank`: the bank currently filling.
  - `wr_idx`: the write slot, range 0..N-1.
  - `rd_bank`: the oldest full bank.
- Accept rule: a word is accepted when `in_valid && in_ready`. It is written to `wr_bank[wr_idx]` and `wr_idx` increments.
- A frame closes when either of these holds:
  - the accepted word has `in_last`=1, or
  - `wr_idx` was N-1.
- On close:
  - set `full[wr_bank]` and `count = wr_idx+1`;
  - set `wr_idx` to 0 and toggle `wr_bank`.
- Overlong stream: a stream longer than N without `in_last` splits into consecutive N-word frames. There is no error flag.
- `in_last` on word N: a single close only. No empty frame is created.
- Empty frames cannot occur, because `in_last` is always qualified by a word.
- `in_ready` = !`full[wr_bank]`. It is a registered-state function only, with no combinational path from `in_valid` or `frame_ready`.
- `frame_valid` = `full[rd_bank]`.
- `frame_data` and `frame_count` are driven from `rd_bank`. Pad masking is k ≥ `count[rd_bank]` → PAD.
- Release rule: on `frame_valid && frame_ready`, clear `full[rd_bank]` and toggle `rd_bank`.
- Frame order is strictly FIFO (depth 2).
- Simultaneous accept and release, whether on different banks or on the same bank: both take effect in the same edge. Release frees a bank; `in_ready` rises the next cycle.
- Stability: while `frame_valid`=1 and `frame_ready`=0, `frame_data` and `frame_count` must stay stable.
- Stale data: bank contents are not cleared on release. Masking guarantees stale words never appear.

## Timing
- Reset values (asynchronous assert, synchronous-edge release):
  - banks and counts cleared to 0;
  - `wr_idx`=0, `wr_bank`=0, `rd_bank`=0, `full`=0;
  - `in_ready`=1, `frame_valid`=0, `frame_data` all PAD, `frame_count`=0.
- Reset mid-frame or mid-hold discards all partial and held frames.
- Latency: `frame_valid` rises the cycle after the edge that accepts the closing word.
- Throughput: with `frame_ready` held high, one word per cycle is sustained indefinitely (`in_ready` stays 1).
- Backpressure: when both banks are full, `in_ready`=0. It returns to 1 one cycle after the release handshake.
- The sorter is combinational, so sorted output is valid in the same cycles as `frame_valid`.

## Structure
- Shared package `sort_pkg`:
  - default `N` and `WIDTH` constants;
  - `PAD` default;
  - `word_t` typedef;
  - `frame_t` typedef (unpacked array of N `word_t`), reused by the sorter and downstream stages.
- Sub-module `sort_frame_bank`:
  - one bank: word registers, count, full flag, write port, release port, pad-masked read output;
  - instantiated twice, with a 2:1 output mux selected by `rd_bank`.
- Top level holds the pointers and handshake logic.

## Test plan
Defaults N=6, WIDTH=8, PAD=8'hFF.
- Reset: assert `rst` mid-fill after 3 words → `frame_valid`=0, `in_ready`=1, and the next full frame contains only post-reset words.
- Full frame: stream 05,03,09,01,07,02 back-to-back with `frame_ready`=1 → next cycle `frame_valid`=1, `frame_count`=6, `frame_data`=[05,03,09,01,07,02].
- Short frame: 0A,04 with `in_last` on 04 → `frame_count`=2, `frame_data`=[0A,04,FF,FF,FF,FF].
- Backpressure: `frame_ready`=0, send 14 words → 12 accepted, `in_ready`=0 after word 12. Raise `frame_ready` for one cycle → frame 1 released, `in_ready`=1 next cycle, frame 2 presented unchanged.
- Overlong/boundary: 7 words with `in_last` on the 7th → frame [1..6] with count 6, then frame [7,FF×5] with count 1. Also: `in_last` on word 6 → exactly one frame.
- Simultaneous: closing word of bank 1 accepted on the same edge bank 0 is released → bank 1 presented next cycle with no lost or duplicated frame.
